// File: rtl/password_enroll.sv
// ============================================================================
// Module  : password_enroll
// Brief   : Two-pass 4-digit password enrollment with LED/HEX status.
//           Optional inactivity abort: define PASSWORD_ENROLL_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module password_enroll #(
  parameter logic [15:0] DEFAULT_CODE  = 16'h2016,
  parameter int unsigned TIMEOUT_TICKS = 200
) (
  input  logic        slow_clk,
  input  logic        rst,
  input  logic        enroll_req,
  input  logic [9:0]  key_pulse,
  output logic [15:0] code_out,
  output logic        code_update,
  output logic        busy,
  output logic [3:0]  status_LED,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER   = 3'd1,
    S_CONFIRM = 3'd2,
    S_DONE    = 3'd3,
    S_FAIL    = 3'd4
  } state_t;

  localparam logic [6:0] c_seg_blank = 7'b1111111;
  localparam logic [6:0] c_seg_dash  = 7'b0111111;
  localparam logic [6:0] c_seg_e     = 7'b0000110;
  localparam logic [6:0] c_seg_c     = 7'b1000110;
  localparam logic [6:0] c_seg_d     = 7'b0100001;
  localparam logic [6:0] c_seg_o     = 7'b0100011;
  localparam logic [6:0] c_seg_n     = 7'b0101011;
  localparam logic [6:0] c_seg_r     = 7'b0101111;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [15:0] r_new_buf;
  logic [15:0] r_cfm_buf;

  state_t      w_state_nxt;
  logic [1:0]  w_cnt_nxt;
  logic [15:0] w_new_nxt;
  logic [15:0] w_cfm_nxt;
  logic        w_commit;
  logic        w_key_valid;
  logic        w_key_multi;
  logic [3:0]  w_digit;
  logic        w_timeout;

  logic [3:0]  w_led_nxt;
  logic [6:0]  w_hex0_nxt;
  logic [6:0]  w_hex1_nxt;
  logic [6:0]  w_hex2_nxt;
  logic [6:0]  w_hex3_nxt;
  logic [6:0]  w_hex4_nxt;

  // Digit slot idx lives in the nibble counted from the MSB end.
  function automatic logic [3:0] get_digit(input logic [15:0] vec, input logic [1:0] idx);
    logic [3:0] d;
    case (idx)
      2'd0:    d = vec[15:12];
      2'd1:    d = vec[11:8];
      2'd2:    d = vec[7:4];
      default: d = vec[3:0];
    endcase
    return d;
  endfunction

  function automatic logic [15:0] set_digit(input logic [15:0] vec, input logic [1:0] idx,
                                            input logic [3:0] d);
    logic [15:0] v;
    v = vec;
    case (idx)
      2'd0:    v[15:12] = d;
      2'd1:    v[11:8]  = d;
      2'd2:    v[7:4]   = d;
      default: v[3:0]   = d;
    endcase
    return v;
  endfunction

  always_comb begin
    w_key_valid = (key_pulse != '0) && ((key_pulse & (key_pulse - 10'd1)) == '0);
    w_key_multi = (key_pulse != '0) && !w_key_valid;
    w_digit     = '0;
    for (int i = 0; i < 10; i++) begin
      if (key_pulse[i]) w_digit = 4'(i);
    end
  end

`ifdef PASSWORD_ENROLL_TIMEOUT_EN
  logic [15:0] r_idle;
  logic [15:0] w_idle_inc;
  logic        w_idle_clr;

  assign w_idle_inc = r_idle + 16'd1;
  assign w_timeout  = (w_idle_inc == 16'(TIMEOUT_TICKS));
  assign w_idle_clr = enroll_req || w_key_valid ||
                      !((w_state_nxt == S_ENTER) || (w_state_nxt == S_CONFIRM));

  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
    end else if (w_idle_clr) begin
      r_idle <= '0;
    end else begin
      r_idle <= w_idle_inc;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_TICKS;
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_new_nxt   = r_new_buf;
    w_cfm_nxt   = r_cfm_buf;
    w_commit    = 1'b0;
    case (r_state)
      S_ENTER, S_CONFIRM: begin
        // A restart request outranks any key arriving in the same cycle.
        if (enroll_req) begin
          w_state_nxt = S_ENTER;
          w_cnt_nxt   = '0;
          w_new_nxt   = '0;
          w_cfm_nxt   = '0;
        end else if (w_key_multi) begin
          w_state_nxt = S_FAIL;
        end else if (w_key_valid && (r_state == S_ENTER)) begin
          w_new_nxt = set_digit(r_new_buf, r_cnt, w_digit);
          w_cnt_nxt = r_cnt + 2'd1;
          if (r_cnt == 2'd3) w_state_nxt = S_CONFIRM;
        end else if (w_key_valid) begin
          w_cfm_nxt = set_digit(r_cfm_buf, r_cnt, w_digit);
          w_cnt_nxt = r_cnt + 2'd1;
          if (w_digit != get_digit(r_new_buf, r_cnt)) begin
            w_state_nxt = S_FAIL;
          end else if (r_cnt == 2'd3) begin
            w_state_nxt = S_DONE;
            w_commit    = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_FAIL;
        end
      end
      default: begin
        if (enroll_req) begin
          w_state_nxt = S_ENTER;
          w_cnt_nxt   = '0;
          w_new_nxt   = '0;
          w_cfm_nxt   = '0;
        end
      end
    endcase
  end

  // Status is derived from the next state so it lands on the same edge.
  always_comb begin
    w_led_nxt  = 4'b0000;
    w_hex0_nxt = c_seg_blank;
    w_hex1_nxt = c_seg_blank;
    w_hex2_nxt = c_seg_blank;
    w_hex3_nxt = c_seg_blank;
    w_hex4_nxt = c_seg_blank;
    case (w_state_nxt)
      S_ENTER, S_CONFIRM: begin
        w_hex4_nxt = (w_state_nxt == S_ENTER) ? c_seg_e : c_seg_c;
        case (w_cnt_nxt)
          2'd1: begin
            w_led_nxt  = 4'b0001;
            w_hex3_nxt = c_seg_dash;
          end
          2'd2: begin
            w_led_nxt  = 4'b0011;
            w_hex3_nxt = c_seg_dash;
            w_hex2_nxt = c_seg_dash;
          end
          2'd3: begin
            w_led_nxt  = 4'b0111;
            w_hex3_nxt = c_seg_dash;
            w_hex2_nxt = c_seg_dash;
            w_hex1_nxt = c_seg_dash;
          end
          default: ;
        endcase
      end
      S_DONE: begin
        w_led_nxt  = 4'b1111;
        w_hex3_nxt = c_seg_d;
        w_hex2_nxt = c_seg_o;
        w_hex1_nxt = c_seg_n;
        w_hex0_nxt = c_seg_e;
      end
      S_FAIL: begin
        w_hex4_nxt = c_seg_e;
        w_hex3_nxt = c_seg_r;
        w_hex2_nxt = c_seg_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_new_buf   <= '0;
      r_cfm_buf   <= '0;
      code_out    <= DEFAULT_CODE;
      code_update <= 1'b0;
      busy        <= 1'b0;
      status_LED  <= 4'b0000;
      HEX0        <= c_seg_blank;
      HEX1        <= c_seg_blank;
      HEX2        <= c_seg_blank;
      HEX3        <= c_seg_blank;
      HEX4        <= c_seg_blank;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_new_buf   <= w_new_nxt;
      r_cfm_buf   <= w_cfm_nxt;
      code_update <= w_commit;
      if (w_commit) code_out <= w_cfm_nxt;
      busy        <= (w_state_nxt == S_ENTER) || (w_state_nxt == S_CONFIRM);
      status_LED  <= w_led_nxt;
      HEX0        <= w_hex0_nxt;
      HEX1        <= w_hex1_nxt;
      HEX2        <= w_hex2_nxt;
      HEX3        <= w_hex3_nxt;
      HEX4        <= w_hex4_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_password_enroll.sv
// ============================================================================
// Module  : tb_password_enroll
// Brief   : Directed + randomized bench for password_enroll against a
//           queue-based enrollment model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_password_enroll;

  localparam int TICKS = 20;

  logic        slow_clk = 1'b0;
  logic        rst = 1'b0;
  logic        enroll_req = 1'b0;
  logic [9:0]  key_pulse = '0;
  logic [15:0] code_out;
  logic        code_update;
  logic        busy;
  logic [3:0]  status_LED;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4;

  int n_vec = 0;
  int n_err = 0;

  password_enroll #(.DEFAULT_CODE(16'h2016), .TIMEOUT_TICKS(TICKS)) dut (
    .slow_clk(slow_clk), .rst(rst), .enroll_req(enroll_req), .key_pulse(key_pulse),
    .code_out(code_out), .code_update(code_update), .busy(busy), .status_LED(status_LED),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4)
  );

  always #5 slow_clk = ~slow_clk;

  // Reference model: phase 0 idle, 1 first entry, 2 confirmation, 3 done, 4 fail.
  int          m_phase;
  int          m_first[$];
  int          m_second[$];
  logic [15:0] m_code;
  logic        m_upd;
  int          m_idle;

  function automatic logic [9:0] oh(input int d);
    logic [9:0] v;
    v = 10'd1 << d;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_first.delete();
    m_second.delete();
    m_code = 16'h2016;
    m_upd = 1'b0;
    m_idle = 0;
  endtask

  task automatic model_step(input logic er, input logic [9:0] k);
    int ones;
    int d;
    ones = $countones(k);
    d = 0;
    for (int i = 0; i < 10; i++) if (k[i]) d = i;
    m_upd = 1'b0;
    if (er) begin
      m_phase = 1;
      m_first.delete();
      m_second.delete();
      m_idle = 0;
    end else if (m_phase == 1 || m_phase == 2) begin
      if (ones > 1) begin
        m_phase = 4;
      end else if (ones == 1) begin
        m_idle = 0;
        if (m_phase == 1) begin
          m_first.push_back(d);
          if (m_first.size() == 4) m_phase = 2;
        end else if (d != m_first[m_second.size()]) begin
          m_phase = 4;
        end else begin
          m_second.push_back(d);
          if (m_second.size() == 4) begin
            m_phase = 3;
            m_upd = 1'b1;
            m_code = {4'(m_first[0]), 4'(m_first[1]), 4'(m_first[2]), 4'(m_first[3])};
          end
        end
      end else begin
`ifdef PASSWORD_ENROLL_TIMEOUT_EN
        m_idle++;
        if (m_idle == TICKS) m_phase = 4;
`endif
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [6:0] h[5];
    logic [3:0] led;
    int n;
    for (int i = 0; i < 5; i++) h[i] = 7'b1111111;
    led = 4'b0000;
    n = (m_phase == 1) ? m_first.size() : (m_phase == 2) ? m_second.size() : 0;
    if (m_phase == 1 || m_phase == 2) begin
      h[4] = (m_phase == 1) ? 7'b0000110 : 7'b1000110;
      led = 4'((1 << n) - 1);
      for (int i = 0; i < n; i++) h[3 - i] = 7'b0111111;
    end else if (m_phase == 3) begin
      led = 4'b1111;
      h[3] = 7'b0100001; h[2] = 7'b0100011; h[1] = 7'b0101011; h[0] = 7'b0000110;
    end else if (m_phase == 4) begin
      h[4] = 7'b0000110; h[3] = 7'b0101111; h[2] = 7'b0101111;
    end
    chk({tag, ".code_out"}, code_out, m_code);
    chk({tag, ".code_update"}, 16'(code_update), 16'(m_upd));
    chk({tag, ".busy"}, 16'(busy), 16'(m_phase == 1 || m_phase == 2));
    chk({tag, ".status_LED"}, 16'(status_LED), 16'(led));
    chk({tag, ".HEX0"}, 16'(HEX0), 16'(h[0]));
    chk({tag, ".HEX1"}, 16'(HEX1), 16'(h[1]));
    chk({tag, ".HEX2"}, 16'(HEX2), 16'(h[2]));
    chk({tag, ".HEX3"}, 16'(HEX3), 16'(h[3]));
    chk({tag, ".HEX4"}, 16'(HEX4), 16'(h[4]));
  endtask

  task automatic apply(input string tag, input logic er, input logic [9:0] k);
    @(negedge slow_clk);
    enroll_req = er;
    key_pulse  = k;
    @(posedge slow_clk);
    model_step(er, k);
    #1;
    check_all(tag);
    enroll_req = 1'b0;
    key_pulse  = '0;
  endtask

  initial begin : stim
    int d[4];
    int mode;
    int pos;
    int a;
    int b;
    logic [9:0] k;

    // Reset and default code.
    model_reset();
    #12;
    check_all("reset");
    @(negedge slow_clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) apply("idle_keys", 1'b0, 10'($urandom_range(0, 1023)));

    // Successful enrollment of 7391.
    apply("enroll", 1'b1, '0);
    foreach (d[i]) d[i] = 0;
    for (int r = 0; r < 2; r++) begin
      apply("k7", 1'b0, oh(7));
      apply("k3", 1'b0, oh(3));
      apply("k9", 1'b0, oh(9));
      apply("k1", 1'b0, oh(1));
    end
    chk("commit_code", code_out, 16'h7391);
    apply("done_hold", 1'b0, oh(2));

    // Confirmation mismatch.
    apply("enroll2", 1'b1, '0);
    apply("m7", 1'b0, oh(7)); apply("m3", 1'b0, oh(3));
    apply("m9", 1'b0, oh(9)); apply("m1", 1'b0, oh(1));
    apply("c7", 1'b0, oh(7)); apply("c4", 1'b0, oh(4));
    apply("fail_hold", 1'b0, oh(3));

    // Multi-hot key during entry, then recovery.
    apply("enroll3", 1'b1, '0);
    apply("multi", 1'b0, 10'b0000000101);
    apply("recover", 1'b1, oh(5));

    // Restart after two digits, with a key in the restart cycle.
    apply("r1", 1'b0, oh(4));
    apply("r2", 1'b0, oh(8));
    apply("restart", 1'b1, oh(6));

    // Randomized enrollments.
    for (int it = 0; it < 30; it++) begin
      apply("rnd_req", 1'b1, ($urandom_range(0, 1) == 1) ? oh($urandom_range(0, 9)) : 10'd0);
      for (int j = 0; j < 4; j++) begin
        d[j] = $urandom_range(0, 9);
        apply("rnd_enter", 1'b0, oh(d[j]));
        repeat ($urandom_range(0, 2)) apply("rnd_gap", 1'b0, '0);
      end
      mode = $urandom_range(0, 3);
      pos  = $urandom_range(0, 3);
      for (int j = 0; j < 4; j++) begin
        k = oh(d[j]);
        if (mode == 1 && j == pos) k = oh((d[j] + 1 + $urandom_range(0, 8)) % 10);
        if (mode == 2 && j == pos) begin
          a = $urandom_range(0, 9);
          b = (a + 1 + $urandom_range(0, 8)) % 10;
          k = oh(a) | oh(b);
        end
        if (mode == 3 && j == pos) apply("rnd_restart", 1'b1, '0);
        else apply("rnd_confirm", 1'b0, k);
      end
    end

    // Re-enrolling the committed code still pulses the update.
    apply("same_req", 1'b1, '0);
    for (int r = 0; r < 2; r++) begin
      apply("s7", 1'b0, oh(7)); apply("s3", 1'b0, oh(3));
      apply("s9", 1'b0, oh(9)); apply("s1", 1'b0, oh(1));
    end
    apply("enroll_same2", 1'b1, '0);
    for (int j = 0; j < 4; j++) apply("same2_enter", 1'b0, oh(m_code[15 - 4 * j -: 4] % 10));
    for (int j = 0; j < 4; j++) apply("same2_conf", 1'b0, oh(m_first[j]));

    // Asynchronous reset during confirmation.
    apply("rst_req", 1'b1, '0);
    apply("e0", 1'b0, oh(1)); apply("e1", 1'b0, oh(2));
    apply("e2", 1'b0, oh(3)); apply("e3", 1'b0, oh(4));
    apply("cf0", 1'b0, oh(1));
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge slow_clk);
    rst = 1'b1;
    apply("post_rst", 1'b0, oh(1));

    // Inactivity after one key.
    apply("to_req", 1'b1, '0);
    apply("to_key", 1'b0, oh(5));
    for (int i = 0; i < TICKS + 2; i++) apply("to_idle", 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/password_enroll.md
# password_enroll

Password enrollment (writer) block for the switch/HEX lock. It collects a new 4-digit code from one-hot key pulses, then requires the same code entered again as confirmation. On a match it commits the code to a register that the checker reads. Status is shown on LEDs and seven-segment displays. It runs on the divided `slow_clk` and takes its keys from the existing one-shot chain.

## Interface
- `DEFAULT_CODE`, 16'h2016: code loaded at reset; digit0 in [15:12], digit3 in [3:0], BCD.
- `TIMEOUT_TICKS`, 200: `slow_clk` cycles of inactivity before abort; used only with the timeout macro.
- `slow_clk` in 1: block clock.
- `rst` in 1: reset, asynchronous, active-low.
- `enroll_req` in 1: one-cycle pulse that starts or restarts enrollment.
- `key_pulse` in 10: one-cycle key pulses; bit i means digit i.
- `code_out` out 16: committed code, 4 BCD digits, digit0 in MSBs.
- `code_update` out 1: one-cycle pulse in the cycle `code_out` changes.
- `busy` out 1: high in ENTER and CONFIRM.
- `status_LED` out 4: progress indicator.
- `HEX0`..`HEX4` out 7 each: active-low segments; bit6 = g, bit0 = a.

## Operation
- States: IDLE, ENTER, CONFIRM, DONE, FAIL. All outputs are registered.
- Key decode:
  - A key is accepted when exactly one bit of `key_pulse` is set; digit = index of that bit.
  - All-zero: no action.
  - More than one bit set in ENTER or CONFIRM: go to FAIL.
- IDLE:
  - Keys are ignored.
  - `enroll_req` -> ENTER with digit count cnt=0 and both buffers cleared.
- ENTER:
  - Accepted digit is written to `new_buf[cnt]` and cnt increments.
  - The 4th digit -> CONFIRM with cnt=0.
- CONFIRM:
  - Accepted digit is compared to `new_buf[cnt]`; a mismatch -> FAIL immediately.
  - A 4th matching digit -> DONE. On that transition `code_out` <= `new_buf` and `code_update`=1 for one cycle.
- DONE and FAIL:
  - Hold until `enroll_req`, then -> ENTER with cnt=0.
  - `code_out` is unchanged by FAIL.
- `enroll_req` in ENTER or CONFIRM: restart at ENTER with cnt=0 and buffers cleared. Any key in the same cycle is ignored.
- `status_LED`:
  - ENTER and CONFIRM: thermometer of cnt (0 -> 0000, 1 -> 0001, 2 -> 0011, 3 -> 0111).
  - DONE: 1111.
  - IDLE and FAIL: 0000.
- Display, blank = 7'b1111111:
  - IDLE: all blank.
  - ENTER: HEX4 shows 'E' = 7'b0000110.
  - CONFIRM: HEX4 shows 'C' = 7'b1000110.
  - ENTER and CONFIRM: HEX3..HEX0 show '-' = 7'b0111111 for each digit entered, filled from HEX3; the rest are blank.
  - DONE: HEX4 blank, HEX3..HEX0 = 'd' 7'b0100001, 'o' 7'b0100011, 'n' 7'b0101011, 'E' 7'b0000110.
  - FAIL: HEX4 = 'E' 7'b0000110, HEX3 = HEX2 = 'r' 7'b0101111, HEX1 and HEX0 blank.

## Timing
- Reset values:
  - State IDLE, cnt=0, buffers 0.
  - `code_out`=`DEFAULT_CODE`.
  - `code_update`=0, `busy`=0, `status_LED`=0000.
  - All HEX outputs blank.
- Reset asserted mid-enrollment aborts it. The pending code is discarded and `code_out` returns to `DEFAULT_CODE`.
- Latency:
  - A pulse sampled at edge N updates state, LEDs and HEX at edge N.
  - They are visible in the following cycle.
- Commit timing: `code_out` and `code_update` change at the same edge that enters DONE.
- Back-to-back key pulses on consecutive cycles are each accepted.
- Re-entering the committed code is legal; `code_update` still pulses.

## Configuration
- `PASSWORD_ENROLL_TIMEOUT_EN` defined:
  - A 16-bit idle counter runs in ENTER and CONFIRM.
  - It clears on entry to either state and on every accepted key.
  - When it reaches `TIMEOUT_TICKS` the block goes to FAIL.
- Not defined: no counter exists, ENTER and CONFIRM wait indefinitely, and `TIMEOUT_TICKS` is unused.

## Test plan
- Default code: reset, then idle 10 cycles -> `code_out`=16'h2016, `code_update`=0, all HEX blank.
- Successful enrollment: `enroll_req`, keys 7,3,9,1, then 7,3,9,1 -> `code_out`=16'h7391, one `code_update` pulse, `status_LED`=1111, HEX shows "donE".
- Confirm mismatch: `enroll_req`, keys 7,3,9,1, then 7,4 -> FAIL right after key 4, HEX4=7'b0000110, `code_out` unchanged.
- Illegal input: a multi-hot pulse 10'b0000000101 during ENTER -> FAIL. Then `enroll_req` -> ENTER with `status_LED`=0000.
- Restart and reset: `enroll_req` after 2 digits -> cnt=0 and dashes cleared. Asserting `rst` during CONFIRM -> IDLE with `code_out`=16'h2016.
- Timeout (macro on, `TIMEOUT_TICKS`=20): `enroll_req`, one key, then 20 idle cycles -> FAIL. With the macro off, the same stimulus stays in ENTER.
